// File: rtl/uart_pkg.sv
// Shared definitions for the UART bus controller.
//   - Register word indices (byte address bits [3:2])
//   - STATUS register bit positions
//   - RX / TX framing FSM state encodings
package uart_pkg;

  localparam logic [1:0] REG_DATA   = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_DIV    = 2'd2;
  localparam logic [1:0] REG_IEN    = 2'd3;

  localparam int ST_RX_VALID   = 0;
  localparam int ST_TX_BUSY    = 1;
  localparam int ST_RX_OVERRUN = 2;
  localparam int ST_FRAME_ERR  = 3;
  localparam int ST_RX_FULL    = 4;
  localparam int ST_TX_DONE    = 5;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_e;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_STOP
  } tx_state_e;

endpackage

// File: rtl/uart_rx_fifo.sv
// Synchronous FIFO holding received bytes.
// Ports:
//   clk_in, sys_rstn : clock, async active-low reset
//   push_i, wdata_i  : write request and data (dropped when full unless popping)
//   pop_i            : read request (ignored when empty)
//   rdata_o          : current head entry (only meaningful when not empty)
//   empty_o, full_o  : occupancy flags
module uart_rx_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             clk_in,
  input  logic             sys_rstn,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             empty_o,
  output logic             full_o
);

  localparam int AW = $clog2(DEPTH);

  // One extra pointer bit distinguishes full from empty.
  logic [AW:0]      wr_ptr_q, rd_ptr_q;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push, do_pop;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

  // A simultaneous pop frees the slot, so a push into a full FIFO is still taken.
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];

  always_ff @(posedge clk_in or negedge sys_rstn) begin
    if (!sys_rstn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk_in) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/uart_bus_ctrl.sv
// Memory-mapped 8N1 UART controller.
// Ports:
//   clk_in, sys_rstn : clock, async active-low reset
//   uart_rxd         : serial input (asynchronous, idle high)
//   uart_txd         : serial output (registered, idle high)
//   bus_addr         : word select DATA/STATUS/DIV/IRQ_EN
//   bus_we, bus_re   : single-cycle write / read strobes
//   bus_wdata        : write data
//   bus_rdata        : read data, combinational from bus_addr
//   irq              : registered level interrupt
module uart_bus_ctrl
  import uart_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int DIV_W      = 16,
  parameter int DIV_RESET  = 16
) (
  input  logic        clk_in,
  input  logic        sys_rstn,
  input  logic        uart_rxd,
  output logic        uart_txd,
  input  logic [1:0]  bus_addr,
  input  logic        bus_we,
  input  logic        bus_re,
  input  logic [31:0] bus_wdata,
  output logic [31:0] bus_rdata,
  output logic        irq
);

  localparam logic [DIV_W-1:0] DIV_ONE = DIV_W'(1);

  // ---------------- bus decode / control registers ----------------
  logic             wr_data, wr_status, wr_div, wr_ien, rd_data;
  logic [DIV_W-1:0] div_q;
  logic [1:0]       ien_q;
  logic             overrun_q, ferr_q, tx_done_q, irq_q;
  logic             tx_start, tx_done_set, rx_push, rx_ferr_set;
  logic             fifo_empty, fifo_full;
  logic [7:0]       fifo_head;
  logic             unused_wdata;

  assign wr_data   = bus_we && (bus_addr == REG_DATA);
  assign wr_status = bus_we && (bus_addr == REG_STATUS);
  assign wr_div    = bus_we && (bus_addr == REG_DIV);
  assign wr_ien    = bus_we && (bus_addr == REG_IEN);
  assign rd_data   = bus_re && (bus_addr == REG_DATA);

  assign unused_wdata = ^bus_wdata;

  // ---------------- RX synchronizer ----------------
  logic [1:0] rx_sync_q;
  logic       rx_prev_q;
  logic       rxs;

  assign rxs = rx_sync_q[1];

  always_ff @(posedge clk_in or negedge sys_rstn) begin
    if (!sys_rstn) begin
      rx_sync_q <= 2'b11;
      rx_prev_q <= 1'b1;
    end else begin
      rx_sync_q <= {rx_sync_q[0], uart_rxd};
      rx_prev_q <= rxs;
    end
  end

  // ---------------- TX FSM ----------------
  tx_state_e        tx_state_q, tx_state_d;
  logic [DIV_W-1:0] tx_cnt_q, tx_cnt_d, tx_div_q, tx_div_d;
  logic [2:0]       tx_bit_q, tx_bit_d;
  logic [7:0]       tx_shift_q, tx_shift_d;
  logic             txd_q, txd_d;

  assign tx_start = wr_data && (tx_state_q == TX_IDLE);

  always_comb begin
    tx_state_d  = tx_state_q;
    tx_cnt_d    = tx_cnt_q;
    tx_div_d    = tx_div_q;
    tx_bit_d    = tx_bit_q;
    tx_shift_d  = tx_shift_q;
    txd_d       = txd_q;
    tx_done_set = 1'b0;
    case (tx_state_q)
      TX_IDLE: begin
        if (tx_start) begin
          tx_state_d = TX_START;
          tx_shift_d = bus_wdata[7:0];
          tx_div_d   = div_q;
          tx_cnt_d   = div_q - DIV_ONE;
          txd_d      = 1'b0;
        end
      end
      TX_START: begin
        if (tx_cnt_q == '0) begin
          tx_state_d = TX_DATA;
          tx_cnt_d   = tx_div_q - DIV_ONE;
          tx_bit_d   = 3'd0;
          txd_d      = tx_shift_q[0];
        end else begin
          tx_cnt_d = tx_cnt_q - DIV_ONE;
        end
      end
      TX_DATA: begin
        if (tx_cnt_q == '0) begin
          tx_cnt_d = tx_div_q - DIV_ONE;
          if (tx_bit_q == 3'd7) begin
            tx_state_d = TX_STOP;
            txd_d      = 1'b1;
          end else begin
            tx_bit_d   = tx_bit_q + 3'd1;
            tx_shift_d = {1'b0, tx_shift_q[7:1]};
            txd_d      = tx_shift_q[1];
          end
        end else begin
          tx_cnt_d = tx_cnt_q - DIV_ONE;
        end
      end
      TX_STOP: begin
        if (tx_cnt_q == '0) begin
          tx_state_d  = TX_IDLE;
          tx_done_set = 1'b1;
        end else begin
          tx_cnt_d = tx_cnt_q - DIV_ONE;
        end
      end
      default: tx_state_d = TX_IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge sys_rstn) begin
    if (!sys_rstn) begin
      tx_state_q <= TX_IDLE;
      tx_cnt_q   <= '0;
      tx_div_q   <= DIV_W'(DIV_RESET);
      tx_bit_q   <= '0;
      tx_shift_q <= '0;
      txd_q      <= 1'b1;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_div_q   <= tx_div_d;
      tx_bit_q   <= tx_bit_d;
      tx_shift_q <= tx_shift_d;
      txd_q      <= txd_d;
    end
  end

  // ---------------- RX FSM ----------------
  rx_state_e        rx_state_q, rx_state_d;
  logic [DIV_W-1:0] rx_cnt_q, rx_cnt_d, rx_div_q, rx_div_d, rx_half;
  logic [2:0]       rx_bit_q, rx_bit_d;
  logic [7:0]       rx_shift_q, rx_shift_d;

  assign rx_half = div_q >> 1;

  // The cycle that detects the falling edge is the first cycle of the
  // half-bit wait, so the counter runs one short of floor(DIV/2); with
  // DIV=1 the start bit is confirmed on the edge itself.
  always_comb begin
    rx_state_d  = rx_state_q;
    rx_cnt_d    = rx_cnt_q;
    rx_div_d    = rx_div_q;
    rx_bit_d    = rx_bit_q;
    rx_shift_d  = rx_shift_q;
    rx_push     = 1'b0;
    rx_ferr_set = 1'b0;
    case (rx_state_q)
      RX_IDLE: begin
        if (rx_prev_q && !rxs) begin
          rx_div_d = div_q;
          rx_bit_d = 3'd0;
          if (rx_half == '0) begin
            rx_state_d = RX_DATA;
            rx_cnt_d   = '0;
          end else begin
            rx_state_d = RX_START;
            rx_cnt_d   = rx_half - DIV_ONE;
          end
        end
      end
      RX_START: begin
        if (rx_cnt_q == '0) begin
          if (!rxs) begin
            rx_state_d = RX_DATA;
            rx_cnt_d   = rx_div_q - DIV_ONE;
            rx_bit_d   = 3'd0;
          end else begin
            rx_state_d = RX_IDLE;
          end
        end else begin
          rx_cnt_d = rx_cnt_q - DIV_ONE;
        end
      end
      RX_DATA: begin
        if (rx_cnt_q == '0) begin
          rx_shift_d = {rxs, rx_shift_q[7:1]};
          rx_cnt_d   = rx_div_q - DIV_ONE;
          if (rx_bit_q == 3'd7) rx_state_d = RX_STOP;
          else                  rx_bit_d   = rx_bit_q + 3'd1;
        end else begin
          rx_cnt_d = rx_cnt_q - DIV_ONE;
        end
      end
      RX_STOP: begin
        if (rx_cnt_q == '0) begin
          rx_state_d = RX_IDLE;
          if (rxs) rx_push     = 1'b1;
          else     rx_ferr_set = 1'b1;
        end else begin
          rx_cnt_d = rx_cnt_q - DIV_ONE;
        end
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge sys_rstn) begin
    if (!sys_rstn) begin
      rx_state_q <= RX_IDLE;
      rx_cnt_q   <= '0;
      rx_div_q   <= DIV_W'(DIV_RESET);
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
    end else begin
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_div_q   <= rx_div_d;
      rx_bit_q   <= rx_bit_d;
      rx_shift_q <= rx_shift_d;
    end
  end

  // ---------------- RX FIFO ----------------
  uart_rx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk_in  (clk_in),
    .sys_rstn(sys_rstn),
    .push_i  (rx_push),
    .wdata_i (rx_shift_q),
    .pop_i   (rd_data),
    .rdata_o (fifo_head),
    .empty_o (fifo_empty),
    .full_o  (fifo_full)
  );

  // ---------------- registers, sticky flags, irq ----------------
  // Sets take priority over write-one-to-clear so an event is never lost.
  always_ff @(posedge clk_in or negedge sys_rstn) begin
    if (!sys_rstn) begin
      div_q     <= DIV_W'(DIV_RESET);
      ien_q     <= '0;
      overrun_q <= 1'b0;
      ferr_q    <= 1'b0;
      tx_done_q <= 1'b0;
      irq_q     <= 1'b0;
    end else begin
      if (wr_div)
        div_q <= (bus_wdata[DIV_W-1:0] == '0) ? DIV_ONE : bus_wdata[DIV_W-1:0];
      if (wr_ien)
        ien_q <= bus_wdata[1:0];

      if (rx_push && fifo_full && !rd_data)       overrun_q <= 1'b1;
      else if (wr_status && bus_wdata[ST_RX_OVERRUN]) overrun_q <= 1'b0;

      if (rx_ferr_set)                                ferr_q <= 1'b1;
      else if (wr_status && bus_wdata[ST_FRAME_ERR])  ferr_q <= 1'b0;

      if (tx_done_set)                                tx_done_q <= 1'b1;
      else if (tx_start)                              tx_done_q <= 1'b0;
      else if (wr_status && bus_wdata[ST_TX_DONE])    tx_done_q <= 1'b0;

      irq_q <= (ien_q[0] & ~fifo_empty) | (ien_q[1] & tx_done_q);
    end
  end

  always_comb begin
    bus_rdata = '0;
    case (bus_addr)
      REG_DATA:   bus_rdata[7:0] = fifo_empty ? 8'h00 : fifo_head;
      REG_STATUS: begin
        bus_rdata[ST_RX_VALID]   = ~fifo_empty;
        bus_rdata[ST_TX_BUSY]    = (tx_state_q != TX_IDLE);
        bus_rdata[ST_RX_OVERRUN] = overrun_q;
        bus_rdata[ST_FRAME_ERR]  = ferr_q;
        bus_rdata[ST_RX_FULL]    = fifo_full;
        bus_rdata[ST_TX_DONE]    = tx_done_q;
      end
      REG_DIV:    bus_rdata[DIV_W-1:0] = div_q;
      REG_IEN:    bus_rdata[1:0] = ien_q;
      default:    bus_rdata = '0;
    endcase
  end

  assign uart_txd = txd_q;
  assign irq      = irq_q;

endmodule

// File: doc/uart_bus_ctrl.md
Name: uart_bus_ctrl

Overview:
- Memory-mapped UART controller on the CPU's peripheral bridge.
- Sequences the serial `uart_rxd`/`uart_txd` pins: bit-timing counter, RX/TX framing FSMs and a small RX FIFO.
- Exposes four word registers and an interrupt line to the CPU.
- Frame format is fixed 8N1, LSB first.

Parameters:
- FIFO_DEPTH, 4: RX FIFO entries; must be a power of 2, at least 2.
- DIV_W, 16: width of the baud divisor register.
- DIV_RESET, 16: divisor value after reset, in clk_in cycles per bit.

Ports:
- clk_in  in  1  system clock.
- sys_rstn  in  1  asynchronous active-low reset.
- uart_rxd  in  1  serial receive line; asynchronous, idle high.
- uart_txd  out  1  serial transmit line; idle high.
- bus_addr  in  2  word select (byte address bits [3:2]).
- bus_we  in  1  write strobe, one cycle.
- bus_re  in  1  read strobe, one cycle.
- bus_wdata  in  32  write data.
- bus_rdata  out  32  read data, combinational from bus_addr.
- irq  out  1  level interrupt.

Behaviour:
- Clock and reset: one clock, clk_in; reset sys_rstn is asynchronous, active-low.
- Reset values: uart_txd=1, irq=0, FIFO empty, all flags 0, DIV=DIV_RESET, IRQ_EN=0, both FSMs in IDLE. Reset mid-frame aborts the frame immediately.
- Register map:
  - 0 DATA. Write: bus_wdata[7:0] starts TX. Read: FIFO head in [7:0], zero-extended. A read with bus_re pops one entry. A read when empty returns 0 and does not pop.
  - 1 STATUS, read-only bits: [0] rx_valid (FIFO non-empty), [1] tx_busy, [4] rx_full.
  - 1 STATUS, sticky bits: [2] rx_overrun, [3] frame_err, [5] tx_done. A write of 1 clears the corresponding sticky bit.
  - 2 DIV: [DIV_W-1:0]. A written value of 0 is stored as 1.
  - 3 IRQ_EN: [0] rx interrupt enable, [1] tx-done interrupt enable. Bits [31:2] read as 0.
- Divisor latch: each FSM latches DIV at frame start. A DIV write mid-frame affects only the next frame.
- RX input synchronizer: 2-flop synchronizer on uart_rxd, so the FSM sees the line 2 cycles late. The synchronizer resets to 1.
- RX FSM:
  - IDLE -> START on a synced 1->0 edge. The counter loads floor(DIV/2).
  - START: at count 0, if the line is still 0 go to DATA; otherwise return to IDLE (false start, no flag).
  - DATA: sample every DIV cycles into a shift register, 8 bits, LSB first.
  - STOP: sample after DIV cycles.
    - Sample 1: push the byte. If the FIFO is full, drop the byte and set rx_overrun.
    - Sample 0: drop the byte, set frame_err.
  - STOP -> IDLE. In IDLE, an edge requires the line to have been seen high first.
- TX FSM:
  - A DATA write in IDLE loads the byte; the FSM enters START on the next cycle. uart_txd goes 0 one cycle after the write.
  - START, DATA b0..b7, STOP each last exactly DIV cycles. uart_txd is driven from a register, glitch-free.
  - At the end of STOP: go to IDLE and set tx_done.
  - tx_busy=1 from the cycle after the write until return to IDLE.
  - A DATA write while busy is ignored.
  - A new accepted write clears tx_done.
- FIFO:
  - Pointers are log2(FIFO_DEPTH)+1 bits and wrap naturally.
  - Push and pop in the same cycle while full: the pop succeeds and the push is accepted (no overrun).
  - Push and pop in the same cycle while empty: the push occurs and the pop is ignored; the read returns 0.
- irq = (IRQ_EN[0] & rx_valid) | (IRQ_EN[1] & tx_done), registered, so it follows the flags by 1 cycle.

Decomposition:
- Package uart_pkg holds:
  - register index constants REG_DATA=0, REG_STATUS=1, REG_DIV=2, REG_IEN=3;
  - STATUS bit positions;
  - RX/TX state enums.
- Natural sub-module: uart_rx_fifo (parameterised synchronous FIFO with push/pop/full/empty).
- The bit-timing counters stay inline, one per FSM.

Test Plan:
1. DIV=4, write DATA=0xA5 -> uart_txd sequence 0,1,0,1,0,0,1,0,1,1 (start, LSB first, stop), each held 4 cycles. tx_busy is 1 for 40 cycles, then tx_done=1. irq=1 only if IRQ_EN[1]=1.
2. DIV=8, drive an RX frame for 0x3C -> rx_valid=1 about 2+4+72 cycles after the start edge. DATA read returns 0x0000003C, then rx_valid=0.
3. DIV=1, five back-to-back valid RX bytes 0x01..0x05 with no reads -> rx_full=1, rx_overrun=1. Reads return 0x01..0x04, then a fifth read returns 0. Writing STATUS=0x4 clears rx_overrun.
4. DIV=8, RX frame with stop bit 0 -> nothing pushed, frame_err=1. Also a 2-cycle low glitch on the idle line -> no push, no flag, FSM back in IDLE.
5. DIV=4, write DATA mid-TX and write DIV=2 mid-TX -> the second byte is never sent and the current frame keeps 4-cycle bits. The next frame uses 2-cycle bits.
6. Assert sys_rstn=0 during TX bit 3 -> uart_txd=1 asynchronously, tx_busy=0, DIV=DIV_RESET. After release, a fresh DATA write transmits normally.
